// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Next-PC operation encodings and default sizing constants
//               shared by the PC sequencer and the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_JUMP   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_e;

    localparam int c_default_width    = 16;
    localparam int c_default_inc_step = 1;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Return-address LIFO with registered occupancy and
//               full/empty status; one push or one pop per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int c_dw = $clog2(DEPTH + 1);
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_dw-1:0]  r_depth;
    logic [c_aw-1:0]  w_wr_idx;
    logic [c_aw-1:0]  w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_depth == c_dw'(DEPTH));
    assign empty     = (r_depth == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !push;
    assign w_wr_idx  = c_aw'(r_depth);
    assign w_rd_idx  = c_aw'(r_depth - c_dw'(1));
    assign top       = r_mem[w_rd_idx];
    assign depth     = r_depth;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + c_dw'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - c_dw'(1);
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Registered program counter with hold/inc/jump/branch and
//               call/return through a return-address stack, plus sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH        = c_default_width,
    parameter int INC_STEP     = c_default_inc_step,
    parameter int DEPTH        = 8,
    parameter int OFFSET_W     = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 pc_op,
    input  logic [WIDTH-1:0]           pc_target,
    input  logic [OFFSET_W-1:0]        pc_offset,
    input  logic                       err_clear,
    output logic [WIDTH-1:0]           pc_out,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam logic [WIDTH-1:0] c_inc_step  = WIDTH'(INC_STEP);
    localparam logic [WIDTH-1:0] c_reset_vec = WIDTH'(RESET_VECTOR);

    logic [WIDTH-1:0] r_pc;
    logic             r_overflow;
    logic             r_underflow;

    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_ret_addr;
    logic [WIDTH-1:0] w_branch_pc;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_unf_set;

    // Return address is taken from the PC before this cycle's update.
    assign w_ret_addr  = r_pc + c_inc_step;
    assign w_branch_pc = r_pc + WIDTH'($signed(pc_offset));

    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (pc_op)
            PC_INC:    w_pc_next = r_pc + c_inc_step;
            PC_JUMP:   w_pc_next = pc_target;
            PC_BRANCH: w_pc_next = w_branch_pc;
            PC_CALL: begin
                if (stack_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_pc_next = pc_target;
                end
            end
            PC_RET: begin
                if (stack_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_pop     = 1'b1;
                    w_pc_next = w_ras_top;
                end
            end
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= c_reset_vec;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            // A new error in the clearing cycle keeps the flag set.
            r_overflow  <= w_ovf_set | (r_overflow & ~err_clear);
            r_underflow <= w_unf_set | (r_underflow & ~err_clear);
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_ret_addr),
        .top       (w_ras_top),
        .depth     (stack_depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign pc_out          = r_pc;
    assign stack_overflow  = r_overflow;
    assign stack_underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer; the next generation of the core's PC register.
- Adds an encoded next-PC operation: hold, increment, absolute jump, PC-relative branch, call and return.
- Call/return use an internal return-address stack (RAS) with full/empty status and sticky error flags.
- Sits between the control unit (drives pc_op and operands) and instruction memory (consumes pc_out).

Parameters:
WIDTH, 16, PC / address width in bits
INC_STEP, 1, increment added by INC and used for return-address computation
DEPTH, 8, RAS entries (>=1)
OFFSET_W, 8, width of signed relative-branch offset (<= WIDTH)
RESET_VECTOR, 0, pc_out value after reset

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_op  in  3  operation: 0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6/7 reserved
pc_target  in  WIDTH  absolute target for JUMP/CALL
pc_offset  in  OFFSET_W  signed two's-complement offset for BRANCH
err_clear  in  1  clears sticky error flags
pc_out  out  WIDTH  current PC, registered
stack_depth  out  $clog2(DEPTH+1)  RAS occupancy, registered
stack_full  out  1  stack_depth == DEPTH
stack_empty  out  1  stack_depth == 0
stack_overflow  out  1  sticky: CALL attempted while full
stack_underflow  out  1  sticky: RET attempted while empty

Behaviour:
- Clock is clk; reset is synchronous and active-high; no asynchronous paths.
- Reset values: pc_out=RESET_VECTOR, stack_depth=0, stack_empty=1, stack_full=0, overflow=0, underflow=0. RAS contents are don't-care.
- Reset has priority over every op, including mid-call sequences: the whole stack is discarded.
- One op per cycle; the effect is visible on pc_out the cycle after the edge that samples pc_op (latency 1).
- HOLD / reserved 6,7: pc_out unchanged, stack unchanged.
- INC: pc_out <= pc_out + INC_STEP, modulo 2^WIDTH (0xFFFF+1 -> 0x0000 at WIDTH=16).
- JUMP: pc_out <= pc_target.
- BRANCH: pc_out <= pc_out + sign-extended pc_offset, modulo 2^WIDTH.
- CALL, not full: push (pc_out + INC_STEP) mod 2^WIDTH; pc_out <= pc_target; depth+1.
- CALL, full: no push; pc_out unchanged; stack_overflow <= 1.
- RET, not empty: pc_out <= top entry; pop; depth-1.
- RET, empty: pc_out unchanged; stack_underflow <= 1.
- Sticky flags: cleared only by reset or err_clear. If err_clear and a new error occur in the same cycle, set wins.
- stack_full and stack_empty are decoded from the registered depth; they are valid the same cycle as stack_depth.
- Push/pop are at most one per cycle, so there is no simultaneous push and pop.
- The pushed return address is computed from pc_out before update.

Decomposition:
- Shared package: pc_op encodings (PC_HOLD..PC_RET) and default WIDTH/INC_STEP constants, reused by the control unit.
- One natural sub-module: ras_stack, a LIFO with push/pop/top/depth/full/empty, parameterised by WIDTH and DEPTH.
- The next-PC mux and flag logic stay in pc_sequencer.

Test Plan:
- Reset held 2 cycles with pc_op=INC -> pc_out=0x0000, depth=0, empty=1, flags 0. Release, INC for 3 cycles -> pc_out 1,2,3.
- At pc=0x0003: JUMP 0x1234 -> 0x1234. INC -> 0x1235. Then JUMP 0xFFFF, INC -> 0x0000 (wrap). At 0x0010, BRANCH offset 0xFE -> 0x000E; BRANCH offset 0x7F -> 0x008D.
- At 0x1234: CALL 0x2000 -> pc 0x2000, depth 1. CALL 0x3000 -> pc 0x3000, depth 2. RET -> 0x2001. RET -> 0x1235, depth 0, empty=1.
- From depth 0: 8 CALLs -> full=1, depth 8. 9th CALL 0x4444 -> pc unchanged, overflow=1, depth 8. 8 RETs unwind in LIFO order. Extra RET -> pc unchanged, underflow=1. err_clear -> both flags 0.
- Simultaneous error and clear: full stack, CALL with err_clear=1 -> overflow=1 afterwards.
- Reset mid-operation: after 3 CALLs, assert reset with pc_op=RET -> pc_out=RESET_VECTOR, depth 0. Next RET -> underflow=1.
